pkt_drain_buffer: RTL and testbench
===================================

Name: pkt_drain_buffer

Overview:
- Downstream consumer of the packet delay-line stage. That stage emits one config_pkg::data_packet_t per cycle and has no backpressure.
- This block captures every packet whose valid bit is set into a circular buffer. It re-presents the payload on a valid/ready interface to the next consumer.
- Packets that arrive while the buffer is full are dropped and counted.

Parameters:
- BUF_DEPTH, default config_pkg::FIFO_DEPTH (16): number of buffer entries. Must be ≥2; any value is legal, not only powers of 2.
- AF_THRESH, default BUF_DEPTH-2: almost_full asserts when level ≥ AF_THRESH.
- CNT_WIDTH, default 16: width of the drop counter.

Ports:
- clk  input  1  sole clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- flush  input  1  synchronous buffer clear.
- packet_in  input  config_pkg::data_packet_t  packet from the upstream stage; .valid qualifies the packet.
- out_data  output  config_pkg::DATA_WIDTH  payload at the head of the buffer.
- out_valid  output  1  buffer non-empty.
- out_ready  input  1  consumer accepts the head.
- level  output  $clog2(BUF_DEPTH+1)  current occupancy.
- almost_full  output  1  level ≥ AF_THRESH.
- drop_count  output  CNT_WIDTH  number of packets dropped, saturating.
- drop_clr  input  1  synchronous clear of drop_count.

Behaviour:
- Clocking and reset:
  - Single clock clk. Reset rst is asynchronous and active-high.
  - On rst: rd_ptr=0, wr_ptr=0, count=0, drop_count=0.
  - Outputs during reset: out_valid=0, out_data=0, level=0, almost_full=0.
  - Storage array is not reset.
- Push: occurs when packet_in.valid=1 and the packet is accepted. The block writes packet_in.data to mem[wr_ptr], then advances wr_ptr.
- Pop: occurs when out_valid & out_ready. rd_ptr advances.
- Pointer wrap: explicit, BUF_DEPTH-1 → 0 (no power-of-2 assumption).
- Occupancy: count is a registered value.
  - count increments on push-only and decrements on pop-only.
  - count is unchanged on simultaneous push+pop.
  - level = count.
- Output masking: out_valid = (count≠0). out_data = mem[rd_ptr] when out_valid, else 0.
- Latency: a packet accepted at edge N is visible on out_valid/out_data after edge N (1 cycle). There is no same-cycle bypass when empty.
- Full (count=BUF_DEPTH):
  - An incoming valid packet is accepted only if a pop occurs in the same cycle. Count stays at BUF_DEPTH.
  - Otherwise the packet is dropped, pointers are unchanged, and drop_count increments.
- Empty: out_ready is ignored and nothing pops. A push proceeds normally.
- drop_count:
  - Saturates at 2^CNT_WIDTH-1.
  - drop_clr has priority over the increment, except that a drop in the same cycle as drop_clr gives drop_count=1.
- flush:
  - Sets rd_ptr, wr_ptr and count to 0 at the next edge.
  - A concurrent push or pop is discarded and is not counted as a drop.
  - drop_count is retained.
- flush and rst together: rst wins.
- Reset asserted mid-stream: all buffered packets are lost. The first valid packet after rst deasserts is written to mem[0].
- No state machine beyond the occupancy FSM: EMPTY, PARTIAL and FULL are derived from count.
- almost_full is derived combinationally from count.

Decomposition:
- config_pkg keeps data_packet_t, DATA_WIDTH and FIFO_DEPTH.
- Add DROP_CNT_WIDTH=16 to config_pkg as the CNT_WIDTH default.
- One natural sub-module: pkt_sat_counter, parameterised width, with inc and clr inputs and a saturating count output. It is used for drop_count.
- Pointer and occupancy logic stays inline.

Test Plan:
- Reset then idle: rst=1 → out_valid=0, out_data=0, level=0, drop_count=0. Release rst with packet_in.valid=0 → all outputs unchanged.
- Basic flow: push data 0xA5A5_0001..0xA5A5_0004 on consecutive cycles with out_ready=0 → level=4, out_data=0xA5A5_0001. Then hold out_ready=1 → the four values emerge in order, and level returns to 0.
- Overflow: BUF_DEPTH=16, push 20 packets with out_ready=0 → level=16, almost_full=1, drop_count=4. Draining yields packets 1..16 only.
- Full with simultaneous push+pop: at level=16, push 0xDEAD_BEEF while out_ready=1 → level stays 16, drop_count unchanged, and 0xDEAD_BEEF drains as the last packet.
- Wrap-around: stream 40 packets with out_ready toggling every cycle → no drops, and the output order matches the input order across pointer wrap.
- Flush/clear corners:
  - flush with level=5 and a concurrent push → level=0 next cycle and drop_count unchanged.
  - drop_clr in the same cycle as a drop → drop_count=1.
  - rst asserted mid-stream → level=0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/config_pkg.sv
// Shared configuration for the packet pipeline: packet format and default sizes.
package config_pkg;

    localparam int DATA_WIDTH     = 32;
    localparam int FIFO_DEPTH     = 16;
    localparam int DROP_CNT_WIDTH = 16;

    typedef struct packed {
        logic                  valid;
        logic [DATA_WIDTH-1:0] data;
    } data_packet_t;

endpackage

// File: rtl/pkt_drain_buffer_pkg.sv
// Types and helpers local to the drain buffer: occupancy state decode.
package pkt_drain_buffer_pkg;

    typedef enum logic [1:0] {
        OCC_EMPTY   = 2'd0,
        OCC_PARTIAL = 2'd1,
        OCC_FULL    = 2'd2
    } occ_state_t;

    // Occupancy state is a pure function of the count; nothing else is stored.
    function automatic occ_state_t occ_decode(input int unsigned cnt, input int unsigned depth);
        if (cnt == 0)
            return OCC_EMPTY;
        else if (cnt >= depth)
            return OCC_FULL;
        else
            return OCC_PARTIAL;
    endfunction

endpackage

// File: rtl/pkt_drain_buffer_if.sv
// Packet input plus valid/ready output handshake of the drain buffer.
interface pkt_drain_buffer_if;
    import config_pkg::*;

    data_packet_t          packet_in;
    logic [DATA_WIDTH-1:0] out_data;
    logic                  out_valid;
    logic                  out_ready;

    // Upstream stage plus downstream consumer side.
    modport master (
        output packet_in,
        output out_ready,
        input  out_data,
        input  out_valid
    );

    // Buffer side.
    modport slave (
        input  packet_in,
        input  out_ready,
        output out_data,
        output out_valid
    );
endinterface

// File: rtl/pkt_sat_counter.sv
// Saturating event counter with synchronous clear; an event coincident with
// a clear leaves the counter at one so that event is not lost.
module pkt_sat_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic             clr,
    output logic [WIDTH-1:0] count
);

    // Clear wins over increment, but a simultaneous event still counts once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            count <= '0;
        else if (clr)
            count <= inc ? WIDTH'(1) : '0;
        else if (inc && (count != '1))
            count <= count + 1'b1;
    end

endmodule

// File: rtl/pkt_drain_buffer.sv
// Captures valid packets from a no-backpressure stage into a circular buffer
// and re-presents them on valid/ready. Packets arriving while full are dropped
// and counted.
module pkt_drain_buffer
    import config_pkg::*;
    import pkt_drain_buffer_pkg::*;
#(
    parameter int BUF_DEPTH = FIFO_DEPTH,
    parameter int AF_THRESH = BUF_DEPTH - 2,
    parameter int CNT_WIDTH = DROP_CNT_WIDTH
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         flush,
    input  logic                         drop_clr,
    pkt_drain_buffer_if.slave            bus,
    output logic [$clog2(BUF_DEPTH+1)-1:0] level,
    output logic                         almost_full,
    output logic [CNT_WIDTH-1:0]         drop_count
);

    localparam int PTR_W = $clog2(BUF_DEPTH);
    localparam int LVL_W = $clog2(BUF_DEPTH + 1);

    logic [DATA_WIDTH-1:0] mem [BUF_DEPTH];
    logic [PTR_W-1:0]      rd_ptr, wr_ptr;
    logic [LVL_W-1:0]      count;
    occ_state_t            occ;
    logic                  pop, push, drop;

    // Explicit wrap so any depth works, not only powers of two.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(BUF_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // Occupancy decode, handshake qualification and drop detection.
    always_comb begin
        occ  = occ_decode(32'(count), BUF_DEPTH);
        pop  = (occ != OCC_EMPTY) && bus.out_ready;
        // When full, a packet only fits if the head leaves in the same cycle.
        push = bus.packet_in.valid && ((occ != OCC_FULL) || pop);
        // A flushed cycle discards everything and is not a drop.
        drop = bus.packet_in.valid && (occ == OCC_FULL) && !pop && !flush;
    end

    // Pointer and occupancy update; flush clears the buffer but not the drop count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= ptr_inc(wr_ptr);
            if (pop)  rd_ptr <= ptr_inc(rd_ptr);
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage write; contents are never reset, occupancy alone marks them live.
    always_ff @(posedge clk) begin
        if (push && !flush)
            mem[wr_ptr] <= bus.packet_in.data;
    end

    // Head is masked to zero when empty so stale storage never leaks out.
    always_comb begin
        bus.out_valid = (occ != OCC_EMPTY);
        bus.out_data  = bus.out_valid ? mem[rd_ptr] : '0;
        level         = count;
        almost_full   = (count >= LVL_W'(AF_THRESH));
    end

    pkt_sat_counter #(.WIDTH(CNT_WIDTH)) u_drop_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (drop),
        .clr   (drop_clr),
        .count (drop_count)
    );

endmodule

// File: tb/tb_pkt_drain_buffer.sv
// Scoreboard bench for pkt_drain_buffer: stimulus queues expected payloads,
// a negedge monitor pops and compares every handshake the DUT completes.
module tb_pkt_drain_buffer;
    import config_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush = 1'b0;
    logic        drop_clr = 1'b0;
    logic [4:0]  level;
    logic        almost_full;
    logic [15:0] drop_count;

    int n_chk  = 0;
    int n_fail = 0;
    logic [31:0] exp_q [$];

    pkt_drain_buffer_if bus ();

    pkt_drain_buffer dut (
        .clk         (clk),
        .rst         (rst),
        .flush       (flush),
        .drop_clr    (drop_clr),
        .bus         (bus),
        .level       (level),
        .almost_full (almost_full),
        .drop_count  (drop_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [31:0] d, input bit accepted);
        bus.packet_in.valid = 1'b1;
        bus.packet_in.data  = d;
        if (accepted) exp_q.push_back(d);
        tick();
        bus.packet_in.valid = 1'b0;
        bus.packet_in.data  = '0;
    endtask

    task automatic drain(input string name);
        bit done = 0;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 64; i++) begin
            if (level == 0) begin
                done = 1;
                break;
            end
            tick();
        end
        bus.out_ready = 1'b0;
        check({name, "_drained"}, {31'd0, done}, 32'd1);
        check({name, "_sb_empty"}, exp_q.size(), 32'd0);
    endtask

    // Monitor: every completed handshake must match the head of the scoreboard.
    initial begin
        forever begin
            @(negedge clk);
            if (bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
                if (exp_q.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL sb_underflow: got %h expected no output", bus.out_data);
                end else begin
                    check("sb_data", bus.out_data, exp_q.pop_front());
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.packet_in = '0;
        bus.out_ready = 1'b0;

        // Reset state, then idle after release.
        #3;
        check("rst_valid", {31'd0, bus.out_valid}, 32'd0);
        check("rst_data", bus.out_data, 32'd0);
        check("rst_level", {27'd0, level}, 32'd0);
        check("rst_af", {31'd0, almost_full}, 32'd0);
        check("rst_drop", {16'd0, drop_count}, 32'd0);
        tick();
        rst = 1'b0;
        tick();
        tick();
        check("idle_valid", {31'd0, bus.out_valid}, 32'd0);
        check("idle_level", {27'd0, level}, 32'd0);

        // Basic flow.
        for (int i = 1; i <= 4; i++) push(32'hA5A5_0000 + i, 1);
        check("basic_level", {27'd0, level}, 32'd4);
        check("basic_head", bus.out_data, 32'hA5A5_0001);
        check("basic_valid", {31'd0, bus.out_valid}, 32'd1);
        drain("basic");

        // Overflow: 20 pushes into 16 entries.
        for (int i = 1; i <= 20; i++) push(32'hB000_0000 + i, i <= 16);
        check("ovf_level", {27'd0, level}, 32'd16);
        check("ovf_af", {31'd0, almost_full}, 32'd1);
        check("ovf_drop", {16'd0, drop_count}, 32'd4);

        // Full with simultaneous push and pop.
        bus.out_ready = 1'b1;
        push(32'hDEAD_BEEF, 1);
        bus.out_ready = 1'b0;
        check("fullpp_level", {27'd0, level}, 32'd16);
        check("fullpp_drop", {16'd0, drop_count}, 32'd4);
        drain("fullpp");

        // Wrap-around: 40 packets, out_ready toggles every cycle.
        begin
            int n = 0;
            int i = 0;
            while (n < 40) begin
                bus.out_ready = (i % 2 == 1);
                if (i % 3 != 2) begin
                    bus.packet_in.valid = 1'b1;
                    bus.packet_in.data  = 32'hC000_0000 + n;
                    exp_q.push_back(32'hC000_0000 + n);
                    n++;
                end else begin
                    bus.packet_in.valid = 1'b0;
                end
                tick();
                i++;
            end
            bus.packet_in = '0;
            bus.out_ready = 1'b0;
        end
        check("wrap_drop", {16'd0, drop_count}, 32'd4);
        drain("wrap");

        // Flush at level 5 with a concurrent push.
        for (int i = 1; i <= 5; i++) push(32'hE000_0000 + i, 1);
        check("flush_pre_level", {27'd0, level}, 32'd5);
        flush = 1'b1;
        push(32'hEEEE_0001, 0);
        flush = 1'b0;
        exp_q.delete();
        check("flush_level", {27'd0, level}, 32'd0);
        check("flush_valid", {31'd0, bus.out_valid}, 32'd0);
        check("flush_drop", {16'd0, drop_count}, 32'd4);

        // drop_clr coinciding with a drop.
        for (int i = 1; i <= 16; i++) push(32'hF100_0000 + i, 1);
        push(32'hF1FF_0001, 0);
        check("drop_inc", {16'd0, drop_count}, 32'd5);
        drop_clr = 1'b1;
        push(32'hF1FF_0002, 0);
        check("drop_clr_with_drop", {16'd0, drop_count}, 32'd1);
        tick();
        drop_clr = 1'b0;
        check("drop_clr_alone", {16'd0, drop_count}, 32'd0);

        // Reset mid-stream: level clears with no clock edge.
        rst = 1'b1;
        #1;
        check("midrst_level", {27'd0, level}, 32'd0);
        check("midrst_valid", {31'd0, bus.out_valid}, 32'd0);
        exp_q.delete();
        tick();
        rst = 1'b0;
        push(32'hF000_0001, 1);
        check("postrst_head", bus.out_data, 32'hF000_0001);
        check("postrst_level", {27'd0, level}, 32'd1);
        drain("postrst");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
